// File: rtl/audio_framer.sv
// audio_framer: buffers an audio stream and serves overlapping frames to the window stage; AUDIO_FRAMER_PREEMPH_EN adds write-side pre-emphasis
module audio_framer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_LEN    = 306,
    parameter int HOP_LEN      = 153,
    parameter int BUF_DEPTH    = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
    input  logic                           sample_valid_i,
    output logic                           sample_ready_o,
    output logic                           overrun_o,
    output logic                           start_o,
    output logic                           valid_to_read_o,
    input  logic                           rd_en_i,
    output logic signed [SAMPLE_WIDTH-1:0] frame_sample_o,
    input  logic                           frame_done_i,
    output logic [15:0]                    frame_count_o
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int OW = AW + 1;
    localparam int IW = $clog2(FRAME_LEN);

    typedef enum logic [2:0] {IDLE, START, PRESENT, WAIT_ACK, WAIT_DONE} state_t;

    state_t                         state, state_nx;
    logic signed [SAMPLE_WIDTH-1:0] ram [BUF_DEPTH];
    logic signed [SAMPLE_WIDTH-1:0] wr_data;
    logic [AW-1:0]                  wr_ptr, base_ptr, rd_addr;
    logic [IW-1:0]                  rd_idx;
    logic [OW-1:0]                  occ, occ_nx;
    logic                           wr, rd, hop, step;

    assign wr     = sample_valid_i && sample_ready_o;
    assign occ_nx = occ + OW'(wr) - (hop ? OW'(HOP_LEN) : '0);

`ifdef AUDIO_FRAMER_PREEMPH_EN
    localparam int PW = SAMPLE_WIDTH + 1;
    logic signed [SAMPLE_WIDTH-1:0] x_prev;
    logic signed [31:0]             prod;
    logic signed [PW-1:0]           diff;

    assign prod    = 32'sd31785 * 32'(x_prev);
    assign diff    = PW'(sample_i) - PW'(prod >>> 15);
    assign wr_data = (diff[PW-1] != diff[PW-2]) ? {diff[PW-1], {(SAMPLE_WIDTH-1){~diff[PW-1]}}}
                                                : diff[SAMPLE_WIDTH-1:0];

    // previous raw sample, advanced only by accepted samples
    always_ff @(posedge clk) begin
        if (rst) x_prev <= '0;
        else if (wr) x_prev <= sample_i;
    end
`else
    assign wr_data = sample_i;
`endif

    // sample storage; contents are never cleared
    always_ff @(posedge clk) begin
        if (wr) ram[wr_ptr] <= wr_data;
    end

    // frame state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // frame sequencing: one presented sample per ack, hop release on the last ack
    always_comb begin
        state_nx        = state;
        start_o         = 1'b0;
        valid_to_read_o = 1'b0;
        rd              = 1'b0;
        hop             = 1'b0;
        step            = 1'b0;
        rd_addr         = base_ptr;
        case (state)
            IDLE:      state_nx = (occ >= OW'(FRAME_LEN)) ? START : IDLE;
            START: begin
                start_o  = 1'b1;
                rd       = 1'b1;
                state_nx = PRESENT;
            end
            PRESENT: begin
                valid_to_read_o = 1'b1;
                state_nx        = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (rd_en_i && rd_idx == IW'(FRAME_LEN - 1)) begin
                    hop      = 1'b1;
                    state_nx = WAIT_DONE;
                end else if (rd_en_i) begin
                    rd       = 1'b1;
                    step     = 1'b1;
                    rd_addr  = base_ptr + AW'(rd_idx) + AW'(1);
                    state_nx = PRESENT;
                end
            end
            WAIT_DONE: state_nx = frame_done_i ? IDLE : WAIT_DONE;
            default:   state_nx = IDLE;
        endcase
    end

    // pointers, occupancy, flow control and the registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            base_ptr       <= '0;
            rd_idx         <= '0;
            occ            <= '0;
            sample_ready_o <= 1'b1;
            overrun_o      <= 1'b0;
            frame_sample_o <= '0;
            frame_count_o  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (sample_valid_i && !sample_ready_o) overrun_o <= 1'b1;
            if (start_o) rd_idx <= '0;
            else if (step) rd_idx <= rd_idx + IW'(1);
            if (hop) begin
                base_ptr      <= base_ptr + AW'(HOP_LEN);
                frame_count_o <= frame_count_o + 16'd1;
            end
            if (rd) frame_sample_o <= ram[rd_addr];
            occ            <= occ_nx;
            sample_ready_o <= occ_nx < OW'(BUF_DEPTH);
        end
    end
endmodule

// File: tb/tb_audio_framer.sv
// tb_audio_framer: random and directed stimulus against a stream-level model of audio_framer
module tb_audio_framer;
    localparam int SW = 16, FL = 306, HOP = 153, DEPTH = 512, MEM = 4096;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [SW-1:0] sample_i;
    logic                 sample_valid_i, sample_ready_o, overrun_o, start_o, valid_to_read_o;
    logic                 rd_en_i, frame_done_i;
    logic signed [SW-1:0] frame_sample_o;
    logic [15:0]          frame_count_o;

    always #5 clk = ~clk;

    audio_framer dut (
        .clk(clk), .rst(rst), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .sample_ready_o(sample_ready_o), .overrun_o(overrun_o), .start_o(start_o),
        .valid_to_read_o(valid_to_read_o), .rd_en_i(rd_en_i), .frame_sample_o(frame_sample_o),
        .frame_done_i(frame_done_i), .frame_count_o(frame_count_o)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // stream model: stored values in write order, frame k sample j is stored[k*HOP+j]
    int store [MEM];
    int m_occ = 0, m_wr = 0, m_frame = 0, m_idx = 0, m_rst_cnt = 0;
    bit m_overrun = 0, acc;
`ifdef AUDIO_FRAMER_PREEMPH_EN
    int m_xp = 0;
    function automatic int pe(input int x, input int xp);
        int y;
        y = x - ((31785 * xp) >>> 15);
        return y > 32767 ? 32767 : (y < -32768 ? -32768 : y);
    endfunction
`endif

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_occ = 0; m_wr = 0; m_frame = 0; m_idx = 0; m_overrun = 0;
`ifdef AUDIO_FRAMER_PREEMPH_EN
            m_xp = 0;
`endif
            m_rst_cnt++;
        end else begin
            acc = sample_valid_i && m_occ < DEPTH;
            if (acc) begin
`ifdef AUDIO_FRAMER_PREEMPH_EN
                store[m_wr % MEM] = pe(int'(sample_i), m_xp);
                m_xp = int'(sample_i);
`else
                store[m_wr % MEM] = int'(sample_i);
`endif
                m_wr++;
                m_occ++;
            end else if (sample_valid_i) m_overrun = 1;
            if (rd_en_i) begin
                m_idx++;
                if (m_idx == FL) begin
                    m_idx = 0;
                    m_frame++;
                    m_occ -= HOP;
                end
            end
        end
    end

    // per-cycle comparison against the model
    int served [$];
    int last_val = 0, seen_rst = 0, n_start = 0, e;
    bit prev_valid = 0;
    initial forever begin
        @(negedge clk);
        if (m_rst_cnt != seen_rst) begin
            seen_rst = m_rst_cnt; last_val = 0; prev_valid = 0;
        end
        if (m_rst_cnt > 0) begin
            chk("ready", int'(sample_ready_o), int'(m_occ < DEPTH));
            chk("overrun", int'(overrun_o), int'(m_overrun));
            chk("frame_count", int'(frame_count_o), m_frame % 65536);
            if (start_o) begin
                n_start++;
                chk("start_data_avail", int'(m_occ >= FL && m_idx == 0), 1);
                chk("start_vs_valid", int'(valid_to_read_o), 0);
            end
            if (valid_to_read_o) begin
                e = store[(m_frame * HOP + m_idx) % MEM];
                chk("sample", int'(frame_sample_o), e);
                chk("valid_width", int'(prev_valid), 0);
                served.push_back(int'(frame_sample_o));
                last_val = e;
            end else chk("sample_hold", int'(frame_sample_o), last_val);
            prev_valid = valid_to_read_o;
        end
    end

    // consumer: ack ack_dly cycles after each valid, frame_done done_dly cycles after the last ack
    int ack_cnt = 0, done_cnt = 0, c_idx = 0, ack_dly = 1, done_dly = 5, n_ack = 0;
    bit cons_on = 1;
    initial begin
        rd_en_i = 0; frame_done_i = 0;
        forever begin
            @(posedge clk); #1;
            rd_en_i = 0; frame_done_i = 0;
            if (rst) begin
                ack_cnt = 0; done_cnt = 0; c_idx = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) frame_done_i = 1;
                end
                if (ack_cnt > 0) begin
                    ack_cnt--;
                    if (ack_cnt == 0) begin
                        rd_en_i = 1; n_ack++; c_idx++;
                        if (c_idx == FL) begin
                            c_idx = 0; done_cnt = done_dly;
                        end
                    end
                end else if (valid_to_read_o && cons_on) ack_cnt = ack_dly;
            end
        end
    end

    task automatic put(input int v);
        int t = 0;
        while (!sample_ready_o && t < 4000) begin
            sample_valid_i = 0; @(posedge clk); #1; t++;
        end
        if (t >= 4000) chk("put_ready_timeout", int'(sample_ready_o), 1);
        sample_i = SW'(v); sample_valid_i = 1;
        @(posedge clk); #1;
        sample_valid_i = 0;
    endtask

    task automatic do_reset();
        rst = 1; sample_valid_i = 0;
        repeat (2) @(posedge clk);
        #1; rst = 0;
        served.delete();
    endtask

    task automatic wait_count(input int n);
        int t = 0;
        while (frame_count_o != 16'(n) && t < 8000) begin @(posedge clk); #1; t++; end
        chk("wait_frames", int'(frame_count_o), n);
    endtask

    task automatic wait_served(input int n);
        int t = 0;
        while (served.size() < n && t < 4000) begin @(posedge clk); #1; t++; end
        chk("wait_served", int'(served.size() >= n), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(sample_ready_o), 1);
        chk({tag, "_overrun"}, int'(overrun_o), 0);
        chk({tag, "_start"}, int'(start_o), 0);
        chk({tag, "_valid"}, int'(valid_to_read_o), 0);
        chk({tag, "_sample"}, int'(frame_sample_o), 0);
        chk({tag, "_count"}, int'(frame_count_o), 0);
    endtask

    int s0, a0;
    initial begin
        rst = 1; sample_i = 0; sample_valid_i = 0;
        repeat (3) @(posedge clk);
        #1; rst = 0;
        chk_reset_outputs("reset");
`ifdef AUDIO_FRAMER_PREEMPH_EN
        chk("pe_model_a", pe(1000, 1000), 30);
        chk("pe_model_b", pe(32767, -32768), 32767);
`endif

        // ramp: three overlapping frames, start timing
        served.delete(); s0 = n_start;
        for (int i = 0; i < 305; i++) put(i);
        chk("no_start_305", n_start - s0, 0);
        put(305);
        chk("start_not_yet", int'(start_o), 0);
        @(posedge clk); #1;
        chk("start_pulse", int'(start_o), 1);
        chk("valid_before", int'(valid_to_read_o), 0);
        @(posedge clk); #1;
        chk("start_once", int'(start_o), 0);
        chk("valid_rise", int'(valid_to_read_o), 1);
        for (int i = 306; i < 612; i++) put(i);
        wait_count(3);
        repeat (10) @(posedge clk);
        #1;
        chk("ramp_served", served.size(), 918);
        chk("ramp_starts", n_start - s0, 3);
        if (served.size() >= 918) begin
            chk("f0_first", served[0], 0);
            chk("f0_last", served[305], 305);
            chk("f1_first", served[306], 153);
            chk("f1_last", served[611], 458);
            chk("f2_first", served[612], 306);
            chk("f2_last", served[917], 611);
        end

        // overflow with a stalled consumer
        do_reset(); cons_on = 0;
        for (int i = 0; i < 520; i++) begin
            sample_i = SW'($urandom); sample_valid_i = 1;
            @(posedge clk); #1;
        end
        sample_valid_i = 0;
        chk("ovf_model_occ", m_occ, 512);
        chk("ovf_model_wr", m_wr, 512);
        chk("ovf_ready_low", int'(sample_ready_o), 0);
        chk("ovf_flag", int'(overrun_o), 1);
        repeat (20) @(posedge clk);
        #1;
        chk("ovf_sticky", int'(overrun_o), 1);
        do_reset(); cons_on = 1;
        chk("ovf_cleared", int'(overrun_o), 0);

        // slow consumer: 7-cycle ack delay
        ack_dly = 7; s0 = n_start;
        for (int i = 0; i < 459; i++) put(int'($urandom_range(0, 65535)) - 32768);
        wait_count(2);
        repeat (20) @(posedge clk);
        #1;
        chk("slow_served", served.size(), 612);
        chk("slow_starts", n_start - s0, 2);

        // reset after the 100th ack abandons the frame
        do_reset(); ack_dly = 1; a0 = n_ack;
        for (int i = 0; i < FL; i++) put(int'($urandom_range(0, 65535)) - 32768);
        for (int t = 0; t < 2000 && n_ack - a0 < 100; t++) begin @(posedge clk); #1; end
        chk("acks_reached", int'(n_ack - a0 >= 100), 1);
        do_reset();
        chk_reset_outputs("midreset");
        s0 = n_start;
        for (int i = 0; i < 305; i++) put(1000 + i);
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_no_start", n_start - s0, 0);
        put(1305);
        wait_served(1);
        if (served.size() >= 1) chk("post_reset_first", served[0], 1000);
        wait_count(1);

        // pre-emphasis corner values
        do_reset();
        put(1000); put(1000); put(-32768); put(32767);
        for (int i = 0; i < 302; i++) put(0);
        wait_served(4);
        if (served.size() >= 4) begin
            chk("pe_s0", served[0], 1000);
            chk("pe_s2", served[2], -32768);
            chk("pe_s3", served[3], 32767);
`ifdef AUDIO_FRAMER_PREEMPH_EN
            chk("pe_s1", served[1], 30);
`else
            chk("pe_s1", served[1], 1000);
`endif
        end
        wait_count(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
